// File: rtl/txpippm_pkg.sv
// Shared types and constants for the TX phase-interpolator PPM sequencer.
// Per-channel FSM encoding and stepsize field layout.
package txpippm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_e;

    localparam int STEP_W  = 5;
    localparam int DIR_BIT = 4;
    localparam int MAG_W   = 4;

endpackage

// File: rtl/txpippm_sequencer_if.sv
// Command bus for the PPM sequencer: valid/ready handshake plus payload.
// master drives commands, slave (the sequencer) returns ready.
interface txpippm_sequencer_if #(
    parameter int CHANNEL_COUNT = 10,
    parameter int COUNT_WIDTH   = 16,
    parameter int PERIOD_WIDTH  = 16
);
    import txpippm_pkg::*;

    logic                     cmd_valid_in;
    logic                     cmd_ready_out;
    logic [CHANNEL_COUNT-1:0] cmd_sel_in;
    logic [STEP_W-1:0]        cmd_stepsize_in;
    logic [COUNT_WIDTH-1:0]   cmd_count_in;
    logic [PERIOD_WIDTH-1:0]  cmd_period_in;

    modport master (
        output cmd_valid_in, cmd_sel_in, cmd_stepsize_in,
        output cmd_count_in, cmd_period_in,
        input  cmd_ready_out
    );

    modport slave (
        input  cmd_valid_in, cmd_sel_in, cmd_stepsize_in,
        input  cmd_count_in, cmd_period_in,
        output cmd_ready_out
    );

endinterface

// File: rtl/txpippm_channel_seq.sv
// One channel: step/hold FSM, step and period counters, phase accumulator.
// A kill (abort or inactive clock) drops to idle without a pulse or done.
module txpippm_channel_seq
    import txpippm_pkg::*;
#(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int PHASE_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    active,
    input  logic                    abort,
    input  logic                    start,
    input  logic [STEP_W-1:0]       stepsize,
    input  logic [COUNT_WIDTH-1:0]  count,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    busy,
    output logic                    done,
    output logic                    en,
    output logic [STEP_W-1:0]       stepsize_out,
    output logic [PHASE_WIDTH-1:0]  phase
);

    chan_state_e             state;
    logic [STEP_W-1:0]       step_q;
    logic [COUNT_WIDTH-1:0]  remain;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] hold;
    logic [PERIOD_WIDTH-1:0] hold_len;
    logic [PHASE_WIDTH-1:0]  mag_ext;
    logic [PHASE_WIDTH-1:0]  delta;
    logic                    kill;

    assign kill     = abort | ~active;
    assign busy     = (state != ST_IDLE);
    assign en       = (state == ST_STEP) & ~kill;
    assign stepsize_out = busy ? step_q : '0;
    // Zero period still needs one hold cycle between pulses.
    assign hold_len = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
    assign mag_ext  = PHASE_WIDTH'(step_q[MAG_W-1:0]);
    assign delta    = step_q[DIR_BIT] ? mag_ext : -mag_ext;

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (!rst_n) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            remain   <= '0;
            period_q <= '0;
            hold     <= '0;
            phase    <= '0;
        end else if (kill) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        step_q   <= stepsize;
                        remain   <= count;
                        period_q <= period;
                        if (count != '0) state <= ST_STEP;
                        else             done  <= 1'b1;
                    end
                end
                ST_STEP: begin
                    phase <= phase + delta;
                    hold  <= hold_len;
                    if (remain == COUNT_WIDTH'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        remain <= remain - COUNT_WIDTH'(1);
                        state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold == PERIOD_WIDTH'(1)) state <= ST_STEP;
                    else                          hold  <= hold - PERIOD_WIDTH'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/txpippm_sequencer.sv
// Multi-channel TXPIPPM step sequencer: command handshake and channel array.
// Each selected channel runs its own step/hold sequence independently.
module txpippm_sequencer
    import txpippm_pkg::*;
#(
    parameter int CHANNEL_COUNT = 10,
    parameter int COUNT_WIDTH   = 16,
    parameter int PERIOD_WIDTH  = 16,
    parameter int PHASE_WIDTH   = 16
) (
    input  logic                                 gtwiz_userclk_tx_usrclk_in,
    input  logic                                 gtwiz_reset_all_n_in,
    input  logic                                 gtwiz_userclk_tx_active_in,
    txpippm_sequencer_if.slave                   cmd,
    input  logic [CHANNEL_COUNT-1:0]             abort_in,
    output logic [CHANNEL_COUNT-1:0]             busy_out,
    output logic [CHANNEL_COUNT-1:0]             done_out,
    output logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] phase_out,
    output logic [CHANNEL_COUNT-1:0]             txpippmen_out,
    output logic [CHANNEL_COUNT-1:0]             txpippmovrden_out,
    output logic [CHANNEL_COUNT-1:0]             txpippmsel_out,
    output logic [CHANNEL_COUNT-1:0]             txpippmpd_out,
    output logic [CHANNEL_COUNT*STEP_W-1:0]      txpippmstepsize_out
);

    logic accept;

    assign cmd.cmd_ready_out = gtwiz_reset_all_n_in
                             & gtwiz_userclk_tx_active_in
                             & ~|abort_in
                             & ~|(cmd.cmd_sel_in & busy_out);
    assign accept = cmd.cmd_valid_in & cmd.cmd_ready_out;

    assign txpippmsel_out    = '1;
    assign txpippmovrden_out = '0;
    assign txpippmpd_out     = '0;

    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
        txpippm_channel_seq #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .PERIOD_WIDTH(PERIOD_WIDTH),
            .PHASE_WIDTH (PHASE_WIDTH)
        ) u_seq (
            .clk         (gtwiz_userclk_tx_usrclk_in),
            .rst_n       (gtwiz_reset_all_n_in),
            .active      (gtwiz_userclk_tx_active_in),
            .abort       (abort_in[i]),
            .start       (accept & cmd.cmd_sel_in[i]),
            .stepsize    (cmd.cmd_stepsize_in),
            .count       (cmd.cmd_count_in),
            .period      (cmd.cmd_period_in),
            .busy        (busy_out[i]),
            .done        (done_out[i]),
            .en          (txpippmen_out[i]),
            .stepsize_out(txpippmstepsize_out[i*STEP_W +: STEP_W]),
            .phase       (phase_out[i*PHASE_WIDTH +: PHASE_WIDTH])
        );
    end

endmodule

// File: tb/tb_txpippm_sequencer.sv
// Directed bench for txpippm_sequencer: vector table plus corner sequences.
// Expected pulse timing and phase values are worked out by hand.
module tb_txpippm_sequencer;

    localparam int NCH = 10;

    typedef struct {
        logic [NCH-1:0] sel;
        logic [4:0]     step;
        logic [15:0]    count;
        logic [15:0]    period;
        int             npulse;
        int             first;
        int             last;
        int             done_at;
        int             nbusy;
        logic [15:0]    phase;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic active;
    logic [NCH-1:0] abort;
    logic [NCH-1:0] busy, done, en, ovrden, psel, pd;
    logic [NCH*16-1:0] phase;
    logic [NCH*5-1:0] stepsz;

    int checks = 0;
    int errors = 0;

    txpippm_sequencer_if #(
        .CHANNEL_COUNT(NCH), .COUNT_WIDTH(16), .PERIOD_WIDTH(16)
    ) cif ();

    txpippm_sequencer #(
        .CHANNEL_COUNT(NCH), .COUNT_WIDTH(16),
        .PERIOD_WIDTH(16), .PHASE_WIDTH(16)
    ) dut (
        .gtwiz_userclk_tx_usrclk_in(clk),
        .gtwiz_reset_all_n_in      (rst_n),
        .gtwiz_userclk_tx_active_in(active),
        .cmd                       (cif),
        .abort_in                  (abort),
        .busy_out                  (busy),
        .done_out                  (done),
        .phase_out                 (phase),
        .txpippmen_out             (en),
        .txpippmovrden_out         (ovrden),
        .txpippmsel_out            (psel),
        .txpippmpd_out             (pd),
        .txpippmstepsize_out       (stepsz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ph(input int ch);
        return phase[ch*16 +: 16];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cif.cmd_valid_in = 1'b0;
        abort = '0;
        active = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [NCH-1:0] s, input logic [4:0] st,
                         input logic [15:0] c, input logic [15:0] p);
        cif.cmd_valid_in    = 1'b1;
        cif.cmd_sel_in      = s;
        cif.cmd_stepsize_in = st;
        cif.cmd_count_in    = c;
        cif.cmd_period_in   = p;
    endtask

    task automatic wait_done(input int ch, input int budget,
                             output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done[ch]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    vec_t vt[7];
    int npl[NCH], fst[NCH], lst[NCH], dcnt[NCH];
    int dat[NCH], nb[NCH], sbad[NCH];

    initial begin
        bit seen;
        int bad, ecnt, dn;

        vt[0] = '{10'b1, 5'b10011, 16'd3, 16'd4, 3, 1, 11, 12, 11, 16'd9};
        vt[1] = '{10'b110, 5'b00010, 16'd2, 16'd0, 2, 1, 3, 4, 3, 16'hFFFC};
        vt[2] = '{10'b1000, 5'b10101, 16'd0, 16'd3, 0, -1, -1, 1, 0, 16'd0};
        vt[3] = '{10'h200, 5'b11111, 16'd1, 16'd7, 1, 1, 1, 2, 1, 16'd15};
        vt[4] = '{10'h201, 5'b00111, 16'd4, 16'd2, 4, 1, 10, 11, 10, 16'hFFE4};
        vt[5] = '{10'b0, 5'b11111, 16'd5, 16'd1, 0, -1, -1, -1, 0, 16'd0};
        vt[6] = '{10'b10000, 5'b10000, 16'd2, 16'd1, 2, 1, 3, 4, 3, 16'd0};

        cif.cmd_valid_in = 1'b0;
        cif.cmd_sel_in = '0;
        cif.cmd_stepsize_in = '0;
        cif.cmd_count_in = '0;
        cif.cmd_period_in = '0;
        abort = '0;
        active = 1'b1;
        rst_n = 1'b0;

        // reset state, with a command held valid
        drive(10'h3FF, 5'b10011, 16'd3, 16'd1);
        tick();
        tick();
        chk("rst_en", 64'(en), 64'(0));
        chk("rst_step", 64'(stepsz), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_phase", 64'(phase[63:0]), 64'(0));
        chk("rst_sel", 64'(psel), 64'(10'h3FF));
        chk("rst_ovr_pd", 64'({ovrden, pd}), 64'(0));
        chk("rst_ready", 64'(cif.cmd_ready_out), 64'(0));

        for (int k = 0; k < 7; k++) begin
            do_reset();
            drive(vt[k].sel, vt[k].step, vt[k].count, vt[k].period);
            #1;
            chk($sformatf("v%0d_ready", k), 64'(cif.cmd_ready_out), 64'(1));
            tick();
            cif.cmd_valid_in = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                npl[i] = 0; fst[i] = -1; lst[i] = -1;
                dcnt[i] = 0; dat[i] = -1; nb[i] = 0; sbad[i] = 0;
            end
            for (int cyc = 1; cyc <= 40; cyc++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (en[i]) begin
                        npl[i]++;
                        if (fst[i] < 0) fst[i] = cyc;
                        lst[i] = cyc;
                    end
                    if (done[i]) begin
                        dcnt[i]++;
                        dat[i] = cyc;
                    end
                    if (busy[i]) nb[i]++;
                    if (busy[i] && stepsz[i*5 +: 5] !== vt[k].step) sbad[i]++;
                    if (!busy[i] && stepsz[i*5 +: 5] !== 5'd0) sbad[i]++;
                end
                tick();
            end
            bad = 0;
            for (int i = 0; i < NCH; i++) begin
                if (vt[k].sel[i]) begin
                    chk($sformatf("v%0d_ch%0d_npulse", k, i), 64'(npl[i]), 64'(vt[k].npulse));
                    chk($sformatf("v%0d_ch%0d_first", k, i), 64'(fst[i]), 64'(vt[k].first));
                    chk($sformatf("v%0d_ch%0d_last", k, i), 64'(lst[i]), 64'(vt[k].last));
                    chk($sformatf("v%0d_ch%0d_ndone", k, i), 64'(dcnt[i]), 64'(1));
                    chk($sformatf("v%0d_ch%0d_done_at", k, i), 64'(dat[i]), 64'(vt[k].done_at));
                    chk($sformatf("v%0d_ch%0d_nbusy", k, i), 64'(nb[i]), 64'(vt[k].nbusy));
                    chk($sformatf("v%0d_ch%0d_stepsz", k, i), 64'(sbad[i]), 64'(0));
                    chk($sformatf("v%0d_ch%0d_phase", k, i), 64'(ph(i)), 64'(vt[k].phase));
                end else begin
                    bad += npl[i] + dcnt[i] + nb[i] + sbad[i];
                    if (ph(i) !== 16'd0) bad++;
                end
            end
            chk($sformatf("v%0d_unselected", k), 64'(bad), 64'(0));
            chk($sformatf("v%0d_consts", k), 64'({psel, ovrden, pd}),
                64'({10'h3FF, 10'h0, 10'h0}));
        end

        // abort during hold
        do_reset();
        drive(10'b1, 5'b10001, 16'd10, 16'd3);
        tick();
        cif.cmd_valid_in = 1'b0;
        tick();
        tick();
        abort = 10'b1;
        #1;
        chk("abort_ready_low", 64'(cif.cmd_ready_out), 64'(0));
        chk("abort_no_en", 64'(en[0]), 64'(0));
        tick();
        chk("abort_busy_low", 64'(busy[0]), 64'(0));
        abort = '0;
        #1;
        chk("abort_ready_back", 64'(cif.cmd_ready_out), 64'(1));
        ecnt = 0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            ecnt += int'(en[0]);
            dn += int'(done[0]);
            tick();
        end
        chk("abort_no_pulse", 64'(ecnt), 64'(0));
        chk("abort_no_done", 64'(dn), 64'(0));
        chk("abort_phase", 64'(ph(0)), 64'(1));

        // tx_active low acts as abort
        do_reset();
        drive(10'b100, 5'b10010, 16'd5, 16'd1);
        tick();
        cif.cmd_valid_in = 1'b0;
        tick();
        active = 1'b0;
        #1;
        chk("inact_ready", 64'(cif.cmd_ready_out), 64'(0));
        tick();
        chk("inact_busy", 64'(busy), 64'(0));
        ecnt = 0;
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) active = 1'b1;
            ecnt += int'(en[2]);
            dn += int'(done[2]);
            tick();
        end
        chk("inact_no_pulse", 64'(ecnt), 64'(0));
        chk("inact_no_done", 64'(dn), 64'(0));
        chk("inact_phase", 64'(ph(2)), 64'(2));

        // reset mid-sequence
        do_reset();
        drive(10'b1, 5'b10001, 16'd5, 16'd2);
        tick();
        cif.cmd_valid_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_phase", 64'(ph(0)), 64'(0));
        ecnt = 0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            ecnt += int'(en[0]);
            dn += int'(done[0]);
            tick();
        end
        chk("midrst_no_pulse", 64'(ecnt), 64'(0));
        chk("midrst_no_done", 64'(dn), 64'(0));

        // climb to +32767, busy back-pressure, then wrap
        do_reset();
        drive(10'b1, 5'b11111, 16'd2184, 16'd0);
        tick();
        drive(10'b1, 5'b10111, 16'd1, 16'd0);
        #1;
        bad = 0;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            if (busy[0] && cif.cmd_ready_out) bad++;
            if (done[0]) seen = 1'b1;
            else begin
                tick();
                #1;
            end
        end
        chk("busy_ready_low", 64'(bad), 64'(0));
        chk("long_done_seen", 64'(seen), 64'(1));
        chk("ready_at_done", 64'(cif.cmd_ready_out), 64'(1));
        chk("phase_32760", 64'(ph(0)), 64'(16'd32760));
        tick();
        cif.cmd_valid_in = 1'b0;
        wait_done(0, 10, seen);
        chk("p7_done_seen", 64'(seen), 64'(1));
        chk("phase_32767", 64'(ph(0)), 64'(16'h7FFF));
        drive(10'b1, 5'b10001, 16'd1, 16'd0);
        #1;
        tick();
        cif.cmd_valid_in = 1'b0;
        wait_done(0, 10, seen);
        chk("wrap_done_seen", 64'(seen), 64'(1));
        chk("phase_wrap", 64'(ph(0)), 64'(16'h8000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
